decode_stage: RTL and testbench

- Instruction-decode stage of the pipelined MIPS core; the consumer end of the Fetch interface.
- Takes the fetched instruction (IR) and its next-PC (NPC), latches them in an IF/ID register, and reads the register file.
- Produces immediates and destination register, registered into an ID/EX register for Execute.
- Detects load-use hazards and raises a stall request back to Fetch.

---
 rtl/mips_pkg.sv | 33 +++
 rtl/reg_file.sv | 45 ++++
 rtl/decode_stage.sv | 170 +++++++++++++++++
 tb/tb_decode_stage.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared MIPS decode constants: opcodes, instruction field positions and
// the link register index used by JAL.
package mips_pkg;

    // Major opcodes (instruction bits 31:26)
    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_XORI  = 6'h0E;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    // Instruction field bit positions
    localparam int OP_MSB  = 31;
    localparam int OP_LSB  = 26;
    localparam int RS_MSB  = 25;
    localparam int RS_LSB  = 21;
    localparam int RT_MSB  = 20;
    localparam int RT_LSB  = 16;
    localparam int RD_MSB  = 15;
    localparam int RD_LSB  = 11;
    localparam int IMM_MSB = 15;
    localparam int TGT_MSB = 25;

    // Link register written by JAL
    localparam logic [4:0] REG_RA = 5'd31;

endpackage

// File: rtl/reg_file.sv
// Two-read / one-write general purpose register file.
// Register 0 reads as zero and never stores; a write to the register being
// read in the same cycle is forwarded to the read port.
module reg_file #(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [REG_AW-1:0] i_ra1,
    input  logic [REG_AW-1:0] i_ra2,
    output logic [DATA_W-1:0] o_rd1,
    output logic [DATA_W-1:0] o_rd2,
    input  logic              i_we,
    input  logic [REG_AW-1:0] i_wa,
    input  logic [DATA_W-1:0] i_wd
);

    localparam int NREG = 1 << REG_AW;

    logic [DATA_W-1:0] r_mem [0:NREG-1];
    logic              w_wr_ok;

    assign w_wr_ok = i_we && (i_wa != '0);

    // Storage: cleared on reset, written on the clock edge (never entry 0)
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NREG; i++) r_mem[i] <= '0;
        end else if (w_wr_ok) begin
            r_mem[i_wa] <= i_wd;
        end
    end

    // Read ports with r0 hardwired and same-cycle write-through
    always_comb begin
        o_rd1 = r_mem[i_ra1];
        o_rd2 = r_mem[i_ra2];
        if (w_wr_ok && (i_wa == i_ra1)) o_rd1 = i_wd;
        if (w_wr_ok && (i_wa == i_ra2)) o_rd2 = i_wd;
        if (i_ra1 == '0) o_rd1 = '0;
        if (i_ra2 == '0) o_rd2 = '0;
    end

endmodule

// File: rtl/decode_stage.sv
// MIPS instruction-decode stage: IF/ID register, register-file read,
// immediate/destination decode, ID/EX register and load-use stall request.
// Optional macro DECODE_BRANCH_EN adds early branch resolution from IF/ID
// (br_taken / br_target outputs).
module decode_stage #(
    parameter int         DATA_W = 32,
    parameter int         REG_AW = 5,
    parameter logic [5:0] OP_LW  = 6'h23
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] if_ir,
    input  logic [DATA_W-1:0] if_npc,
    input  logic              if_valid,
    input  logic              flush,
    input  logic              wb_we,
    input  logic [REG_AW-1:0] wb_addr,
    input  logic [DATA_W-1:0] wb_data,
    output logic              stall_req,
    output logic              id_valid,
    output logic [DATA_W-1:0] id_npc,
    output logic [DATA_W-1:0] id_ir,
    output logic [DATA_W-1:0] id_a,
    output logic [DATA_W-1:0] id_b,
    output logic [DATA_W-1:0] id_imm,
    output logic [REG_AW-1:0] id_dest
`ifdef DECODE_BRANCH_EN
    ,
    output logic              br_taken,
    output logic [DATA_W-1:0] br_target
`endif
);

    import mips_pkg::*;

    logic [DATA_W-1:0] r_ifid_ir;
    logic [DATA_W-1:0] r_ifid_npc;
    logic              r_ifid_valid;

    logic [5:0]        w_op;
    logic [REG_AW-1:0] w_rs, w_rt, w_rd;
    logic [15:0]       w_imm16;
    logic [DATA_W-1:0] w_sext, w_jump, w_imm, w_a, w_b;
    logic [REG_AW-1:0] w_dest;
    logic              w_rt_src;
    logic [5:0]        w_id_op;

    assign w_op    = r_ifid_ir[OP_MSB:OP_LSB];
    assign w_rs    = r_ifid_ir[RS_MSB:RS_LSB];
    assign w_rt    = r_ifid_ir[RT_MSB:RT_LSB];
    assign w_rd    = r_ifid_ir[RD_MSB:RD_LSB];
    assign w_imm16 = r_ifid_ir[IMM_MSB:0];
    assign w_sext  = {{(DATA_W-16){w_imm16[15]}}, w_imm16};
    assign w_jump  = {r_ifid_npc[DATA_W-1:DATA_W-4], r_ifid_ir[TGT_MSB:0], 2'b00};

    reg_file #(.DATA_W(DATA_W), .REG_AW(REG_AW)) u_rf (
        .clk   (clk),
        .reset (reset),
        .i_ra1 (w_rs),
        .i_ra2 (w_rt),
        .o_rd1 (w_a),
        .o_rd2 (w_b),
        .i_we  (wb_we),
        .i_wa  (wb_addr),
        .i_wd  (wb_data)
    );

    // Immediate extension, destination register and whether rt is a source
    always_comb begin
        w_imm    = w_sext;
        w_dest   = '0;
        w_rt_src = 1'b0;
        case (w_op)
            OP_RTYPE: begin
                w_dest   = w_rd;
                w_rt_src = 1'b1;
            end
            OP_ANDI, OP_ORI, OP_XORI: begin
                w_imm  = {{(DATA_W-16){1'b0}}, w_imm16};
                w_dest = w_rt;
            end
            OP_LUI: begin
                w_imm  = {w_imm16, {(DATA_W-16){1'b0}}};
                w_dest = w_rt;
            end
            OP_J: w_imm = w_jump;
            OP_JAL: begin
                w_imm  = w_jump;
                w_dest = REG_RA;
            end
            OP_BEQ, OP_BNE, OP_SW: w_rt_src = 1'b1;
            default: begin
                // remaining ALU-immediate opcodes (0x08-0x0B) and loads write rt
                if ((w_op == OP_LW) || (w_op[5:3] == 3'b001)) w_dest = w_rt;
            end
        endcase
    end

    // Load-use hazard: the load in ID/EX writes a register the IF/ID
    // instruction reads; suppressed while a flush squashes both stages
    assign w_id_op   = id_ir[OP_MSB:OP_LSB];
    assign stall_req = !flush && id_valid && (w_id_op == OP_LW) && (id_dest != '0)
                       && r_ifid_valid
                       && ((id_dest == w_rs) || (w_rt_src && (id_dest == w_rt)));

    // IF/ID register: bubble on flush, hold on stall, else capture fetch
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_ifid_ir    <= '0;
            r_ifid_npc   <= '0;
            r_ifid_valid <= 1'b0;
        end else if (flush) begin
            r_ifid_ir    <= '0;
            r_ifid_npc   <= '0;
            r_ifid_valid <= 1'b0;
        end else if (!stall_req) begin
            r_ifid_ir    <= if_ir;
            r_ifid_npc   <= if_npc;
            r_ifid_valid <= if_valid;
        end
    end

    // ID/EX register: bubble on flush, stall or empty IF/ID, else decoded fields
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            id_valid <= 1'b0;
            id_npc   <= '0;
            id_ir    <= '0;
            id_a     <= '0;
            id_b     <= '0;
            id_imm   <= '0;
            id_dest  <= '0;
        end else if (flush || stall_req || !r_ifid_valid) begin
            id_valid <= 1'b0;
            id_npc   <= '0;
            id_ir    <= '0;
            id_a     <= '0;
            id_b     <= '0;
            id_imm   <= '0;
            id_dest  <= '0;
        end else begin
            id_valid <= 1'b1;
            id_npc   <= r_ifid_npc;
            id_ir    <= r_ifid_ir;
            id_a     <= w_a;
            id_b     <= w_b;
            id_imm   <= w_imm;
            id_dest  <= w_dest;
        end
    end

`ifdef DECODE_BRANCH_EN
    // Early branch/jump resolution from the IF/ID instruction
    always_comb begin
        br_taken  = 1'b0;
        br_target = r_ifid_npc + (w_sext << 2);
        case (w_op)
            OP_BEQ: br_taken = (w_a == w_b);
            OP_BNE: br_taken = (w_a != w_b);
            OP_J, OP_JAL: begin
                br_taken  = 1'b1;
                br_target = w_jump;
            end
            default: br_taken = 1'b0;
        endcase
        if (!r_ifid_valid || stall_req || flush) br_taken = 1'b0;
    end
`endif

endmodule

// File: tb/tb_decode_stage.sv
// Directed self-checking bench for decode_stage.
module tb_decode_stage;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] if_ir = '0;
    logic [31:0] if_npc = '0;
    logic        if_valid = 1'b0;
    logic        flush = 1'b0;
    logic        wb_we = 1'b0;
    logic [4:0]  wb_addr = '0;
    logic [31:0] wb_data = '0;
    logic        stall_req;
    logic        id_valid;
    logic [31:0] id_npc, id_ir, id_a, id_b, id_imm;
    logic [4:0]  id_dest;
`ifdef DECODE_BRANCH_EN
    logic        br_taken;
    logic [31:0] br_target;
`endif

    int checks = 0;
    int failures = 0;

    decode_stage dut (
        .clk       (clk),
        .reset     (reset),
        .if_ir     (if_ir),
        .if_npc    (if_npc),
        .if_valid  (if_valid),
        .flush     (flush),
        .wb_we     (wb_we),
        .wb_addr   (wb_addr),
        .wb_data   (wb_data),
        .stall_req (stall_req),
        .id_valid  (id_valid),
        .id_npc    (id_npc),
        .id_ir     (id_ir),
        .id_a      (id_a),
        .id_b      (id_b),
        .id_imm    (id_imm),
        .id_dest   (id_dest)
`ifdef DECODE_BRANCH_EN
        ,
        .br_taken  (br_taken),
        .br_target (br_target)
`endif
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] itype(input logic [5:0] op, input logic [4:0] rs,
                                          input logic [4:0] rt, input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

    function automatic logic [31:0] rtype(input logic [4:0] rs, input logic [4:0] rt,
                                          input logic [4:0] rd);
        return {6'h00, rs, rt, rd, 5'd0, 6'h20};
    endfunction

    // advance one clock; inputs are changed 1ns after the edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic fetch(input logic [31:0] ir, input logic [31:0] npc);
        if_ir = ir; if_npc = npc; if_valid = 1'b1;
    endtask

    task automatic idle();
        if_ir = '0; if_npc = '0; if_valid = 1'b0; wb_we = 1'b0; flush = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        idle();
        tick(); tick();
        reset = 1'b0;
        #1;
        checks++; if (id_valid !== 1'b0) begin failures++; $display("FAIL rst_valid got=%b exp=0", id_valid); end
        checks++; if (stall_req !== 1'b0) begin failures++; $display("FAIL rst_stall got=%b exp=0", stall_req); end
        // write r5, then load an instruction reading r5 into ID/EX
        wb_we = 1'b1; wb_addr = 5'd5; wb_data = 32'h55;
        tick();
        wb_we = 1'b0;
        fetch(rtype(5'd5, 5'd0, 5'd12), 32'h8);
        tick(); tick();
        checks++; if (id_a !== 32'h55) begin failures++; $display("FAIL pre_rst_a got=%h exp=%h", id_a, 32'h55); end
        // asynchronous reset while loaded
        #2 reset = 1'b1;
        #1;
        checks++; if (id_valid !== 1'b0) begin failures++; $display("FAIL midrst_valid got=%b exp=0", id_valid); end
        checks++; if (id_a !== 32'h0) begin failures++; $display("FAIL midrst_a got=%h exp=0", id_a); end
        checks++; if (id_ir !== 32'h0) begin failures++; $display("FAIL midrst_ir got=%h exp=0", id_ir); end
        tick();
        reset = 1'b0;
        tick(); tick();
        idle();
        tick();
        checks++; if (id_a !== 32'h0) begin failures++; $display("FAIL r5_after_rst got=%h exp=0", id_a); end
        checks++; if (id_valid !== 1'b1) begin failures++; $display("FAIL r5_after_rst_valid got=%b exp=1", id_valid); end
    endtask

    task automatic test_addi();
        idle();
        wb_we = 1'b1; wb_addr = 5'd8; wb_data = 32'h1234;
        tick();
        wb_we = 1'b0;
        fetch(32'h2109FFFC, 32'h104);
        tick();
        idle();
        tick();
        checks++; if (id_valid !== 1'b1) begin failures++; $display("FAIL addi_valid got=%b exp=1", id_valid); end
        checks++; if (id_a !== 32'h1234) begin failures++; $display("FAIL addi_a got=%h exp=%h", id_a, 32'h1234); end
        checks++; if (id_imm !== 32'hFFFFFFFC) begin failures++; $display("FAIL addi_imm got=%h exp=%h", id_imm, 32'hFFFFFFFC); end
        checks++; if (id_dest !== 5'd9) begin failures++; $display("FAIL addi_dest got=%0d exp=9", id_dest); end
        checks++; if (id_npc !== 32'h104) begin failures++; $display("FAIL addi_npc got=%h exp=%h", id_npc, 32'h104); end
        checks++; if (id_ir !== 32'h2109FFFC) begin failures++; $display("FAIL addi_ir got=%h exp=%h", id_ir, 32'h2109FFFC); end
        tick();
    endtask

    task automatic test_bypass();
        idle();
        fetch(rtype(5'd0, 5'd0, 5'd10), 32'h200);
        tick();
        // r0 write during decode of the r0 reader
        fetch(rtype(5'd0, 5'd3, 5'd11), 32'h204);
        wb_we = 1'b1; wb_addr = 5'd0; wb_data = 32'hFFFF;
        tick();
        checks++; if (id_a !== 32'h0) begin failures++; $display("FAIL r0_read got=%h exp=0", id_a); end
        checks++; if (id_dest !== 5'd10) begin failures++; $display("FAIL r0_dest got=%0d exp=10", id_dest); end
        // r3 write during decode of the r3 reader
        if_valid = 1'b0;
        wb_addr = 5'd3; wb_data = 32'd7;
        tick();
        wb_we = 1'b0;
        checks++; if (id_b !== 32'd7) begin failures++; $display("FAIL r3_bypass got=%h exp=7", id_b); end
        checks++; if (id_a !== 32'h0) begin failures++; $display("FAIL r3_rs0 got=%h exp=0", id_a); end
        tick();
    endtask

    task automatic test_load_use();
        int stalls;
        idle();
        stalls = 0;
        fetch(32'h8C220000, 32'h300);            // LW r2,0(r1)
        tick();
        fetch(rtype(5'd2, 5'd2, 5'd4), 32'h304);  // ADD r4,r2,r2
        #1;
        checks++; if (stall_req !== 1'b0) begin failures++; $display("FAIL lu_early_stall got=%b exp=0", stall_req); end
        tick();
        checks++; if (stall_req !== 1'b1) begin failures++; $display("FAIL lu_stall got=%b exp=1", stall_req); end
        checks++; if (id_dest !== 5'd2) begin failures++; $display("FAIL lu_lw_dest got=%0d exp=2", id_dest); end
        if (stall_req) stalls++;
        tick();                                   // stall edge, fetch holds ADD
        if (stall_req) stalls++;
        checks++; if (id_valid !== 1'b0) begin failures++; $display("FAIL lu_bubble got=%b exp=0", id_valid); end
        idle();
        tick();
        if (stall_req) stalls++;
        checks++; if (stalls != 1) begin failures++; $display("FAIL lu_stall_cycles got=%0d exp=1", stalls); end
        checks++; if (id_valid !== 1'b1) begin failures++; $display("FAIL lu_add_valid got=%b exp=1", id_valid); end
        checks++; if (id_dest !== 5'd4) begin failures++; $display("FAIL lu_add_dest got=%0d exp=4", id_dest); end
        tick();
        // LW r2 followed by ADDI r2,r3,1: rt is a destination, not a source
        fetch(32'h8C220000, 32'h310);
        tick();
        fetch(itype(6'h08, 5'd3, 5'd2, 16'd1), 32'h314);
        tick();
        checks++; if (stall_req !== 1'b0) begin failures++; $display("FAIL lu_rt_dest_stall got=%b exp=0", stall_req); end
        // LW r2 followed by SW r2,0(r3): rt is a source
        fetch(32'h8C220000, 32'h318);
        tick();
        fetch(itype(6'h2B, 5'd3, 5'd2, 16'd0), 32'h31C);
        tick();
        checks++; if (stall_req !== 1'b1) begin failures++; $display("FAIL lu_sw_stall got=%b exp=1", stall_req); end
        idle();
        tick(); tick(); tick();
    endtask

    task automatic test_flush_stall();
        idle();
        fetch(32'h8C220000, 32'h400);
        tick();
        fetch(rtype(5'd2, 5'd0, 5'd4), 32'h404);
        tick();
        flush = 1'b1;
        #1;
        checks++; if (stall_req !== 1'b0) begin failures++; $display("FAIL fl_stall got=%b exp=0", stall_req); end
        tick();
        flush = 1'b0;
        if_valid = 1'b0;
        checks++; if (id_valid !== 1'b0) begin failures++; $display("FAIL fl_idex got=%b exp=0", id_valid); end
        tick();
        checks++; if (id_valid !== 1'b0) begin failures++; $display("FAIL fl_ifid got=%b exp=0", id_valid); end
        fetch(itype(6'h0D, 5'd0, 5'd6, 16'h8001), 32'h500);  // ORI r6,r0,0x8001
        tick();
        idle();
        tick();
        checks++; if (id_valid !== 1'b1) begin failures++; $display("FAIL fl_next_valid got=%b exp=1", id_valid); end
        checks++; if (id_imm !== 32'h00008001) begin failures++; $display("FAIL ori_imm got=%h exp=%h", id_imm, 32'h00008001); end
        checks++; if (id_dest !== 5'd6) begin failures++; $display("FAIL ori_dest got=%0d exp=6", id_dest); end
        tick();
    endtask

    task automatic test_back_to_back();
        idle();
        fetch({6'h03, 26'h0000040}, 32'h80000004);             // JAL
        tick();
        fetch(itype(6'h0F, 5'd0, 5'd7, 16'hABCD), 32'h80000008); // LUI r7
        tick();
        checks++; if (id_imm !== 32'h80000100) begin failures++; $display("FAIL jal_imm got=%h exp=%h", id_imm, 32'h80000100); end
        checks++; if (id_dest !== 5'd31) begin failures++; $display("FAIL jal_dest got=%0d exp=31", id_dest); end
        fetch(itype(6'h04, 5'd1, 5'd2, 16'h8000), 32'h8000000C); // BEQ
        tick();
        checks++; if (id_imm !== 32'hABCD0000) begin failures++; $display("FAIL lui_imm got=%h exp=%h", id_imm, 32'hABCD0000); end
        checks++; if (id_dest !== 5'd7) begin failures++; $display("FAIL lui_dest got=%0d exp=7", id_dest); end
        fetch(itype(6'h0C, 5'd0, 5'd9, 16'hF0F0), 32'h80000010); // ANDI r9
        tick();
        checks++; if (id_imm !== 32'hFFFF8000) begin failures++; $display("FAIL beq_imm got=%h exp=%h", id_imm, 32'hFFFF8000); end
        checks++; if (id_dest !== 5'd0) begin failures++; $display("FAIL beq_dest got=%0d exp=0", id_dest); end
        idle();
        tick();
        checks++; if (id_imm !== 32'h0000F0F0) begin failures++; $display("FAIL andi_imm got=%h exp=%h", id_imm, 32'h0000F0F0); end
        checks++; if (id_dest !== 5'd9) begin failures++; $display("FAIL andi_dest got=%0d exp=9", id_dest); end
        tick();
    endtask

`ifdef DECODE_BRANCH_EN
    task automatic test_branch();
        idle();
        fetch(itype(6'h04, 5'd1, 5'd1, 16'd3), 32'h40);   // BEQ r1,r1,+3
        tick();
        checks++; if (br_taken !== 1'b1) begin failures++; $display("FAIL beq_taken got=%b exp=1", br_taken); end
        checks++; if (br_target !== 32'h4C) begin failures++; $display("FAIL beq_target got=%h exp=%h", br_target, 32'h4C); end
        fetch(itype(6'h05, 5'd1, 5'd1, 16'd3), 32'h44);   // BNE r1,r1,+3
        tick();
        checks++; if (br_taken !== 1'b0) begin failures++; $display("FAIL bne_taken got=%b exp=0", br_taken); end
        idle();
        tick();
        checks++; if (br_taken !== 1'b0) begin failures++; $display("FAIL br_invalid got=%b exp=0", br_taken); end
        tick();
    endtask
`endif

    initial begin
        test_reset();
        test_addi();
        test_bypass();
        test_load_use();
        test_flush_stall();
        test_back_to_back();
`ifdef DECODE_BRANCH_EN
        test_branch();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
